csr_trap_seq: RTL
=================

# csr_trap_seq

Multi-cycle trap sequencer for the RV32E core's machine-mode CSR file. It accepts one `ecall` or `mret` request per handshake and drives the CSR write port over several cycles: `mepc`, `mcause` and `mstatus` for `ecall`; `mstatus` for `mret`. It then reads the target CSR and presents a PC redirect to fetch. It sits between decode/execute and the register file's CSR port, and replaces single-cycle CSR side effects with an explicit, checkable sequence.

## Interface
- `ECALL_CAUSE`, default 32'hb: value written to `mcause` on `ecall` (environment call from M-mode).
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset; 0 = reset asserted.
- `trap_valid` input 1: request valid.
- `trap_ready` output 1: sequencer can accept a request.
- `trap_kind` input 2: 2'b00 = ecall, 2'b01 = mret, 2'b1x = illegal.
- `trap_pc` input 32: PC of the trapping instruction.
- `csr_we` output 1: CSR write enable.
- `csr_waddr` output 2: CSR write index (0 mstatus, 1 mtvec, 2 mepc, 3 mcause).
- `csr_wdata` output 32: CSR write data.
- `csr_raddr` output 2: CSR read index, combinational read.
- `csr_rdata` input 32: CSR read data for `csr_raddr`, same cycle.
- `redir_valid` output 1: redirect PC valid.
- `redir_pc` output 32: redirect target.
- `redir_ready` input 1: fetch accepts redirect.
- `trap_err` output 1: one-cycle pulse for an illegal `trap_kind`.
- `trap_cnt` output 32: count of completed redirects; wraps 32'hFFFFFFFF -> 0.

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_STAT_E, W_STAT_R, REDIR, ERR.
- IDLE:
  - `trap_ready`=1.
  - On `trap_valid & trap_ready`: latch `trap_kind` and `trap_pc`.
  - Next state: ecall -> W_EPC; mret -> W_STAT_R; illegal -> ERR.
- W_EPC: `csr_we`=1, waddr=2, wdata=latched pc -> W_CAUSE.
- W_CAUSE: `csr_we`=1, waddr=3, wdata=`ECALL_CAUSE` -> W_STAT_E.
- W_STAT_E:
  - raddr=0, `csr_we`=1, waddr=0.
  - wdata = rdata with bit7 (MPIE) = rdata[3], bit3 (MIE) = 0, bits[12:11] (MPP) = 2'b11; all other bits unchanged.
  - Next state: REDIR.
- W_STAT_R:
  - raddr=0, `csr_we`=1, waddr=0.
  - wdata = rdata with bit3 = rdata[7], bit7 = 1, bits[12:11] = 2'b11.
  - Next state: REDIR.
- REDIR:
  - raddr = 1 (mtvec) for ecall, 2 (mepc) for mret.
  - `redir_valid`=1.
  - `redir_pc` = ecall: {rdata[31:2], 2'b00}; mret: rdata unmodified.
  - Stays in REDIR until `redir_ready`=1; on that cycle `trap_cnt` increments and next state is IDLE.
- ERR: `trap_err`=1 for exactly one cycle, no CSR write, `trap_cnt` unchanged -> IDLE.
- Outside the states above: `csr_we`=0 and `redir_valid`=0. `csr_waddr`, `csr_wdata`, `csr_raddr` and `redir_pc` are 0 whenever not in use.
- Only one request is in flight. `trap_valid` while busy is ignored (no queue); the requester holds it until accepted.

## Timing
- Reset (`rst`=0, asynchronous):
  - State goes to IDLE, latches clear, `trap_cnt`=0.
  - Every output is 0, including `trap_ready`, which is gated low while reset is asserted.
  - After release, `trap_ready`=1 from the first cycle.
- Reset asserted mid-sequence aborts immediately. Writes already landed remain in the CSR file; no further `csr_we` is issued.
- Ecall, request accepted at edge E0:
  - `csr_we` high during cycles E0..E0+3 (mepc, mcause, mstatus).
  - `redir_valid` high from E0+3.
  - With `redir_ready`=1, IDLE at E0+4 and `trap_ready`=1 in that cycle.
  - Minimum 4 busy cycles.
- Mret, accepted at E0:
  - mstatus write in cycle E0..E0+1.
  - REDIR from E0+1, IDLE at E0+2 minimum.
- Illegal kind: `trap_err` high for cycle E0..E0+1, IDLE at E0+1.
- `csr_rdata` is consumed combinationally in the same cycle as `csr_raddr`; no read latency.
- `redir_valid`/`redir_pc` stay stable while `redir_ready`=0.
- A new request may be accepted in the first IDLE cycle after REDIR (back-to-back, no bubble beyond the IDLE cycle).

## Test plan
- Reset, then ecall with pc=0x80000010, CSR model holding mstatus=0x1808 and mtvec=0x80001003:
  - Writes mepc=0x80000010, mcause=0xb, mstatus=0x1880, in that order on consecutive cycles.
  - `redir_pc`=0x80001000, `trap_cnt`=1.
- Mret with mepc=0x80000014, mstatus=0x1880: mstatus write 0x1888, `redir_pc`=0x80000014, 2-cycle minimum latency.
- Ecall with `redir_ready` held 0 for 5 cycles: `redir_valid` and `redir_pc` stable throughout, `trap_ready`=0, a second `trap_valid` ignored; completes one cycle after `redir_ready`=1.
- `trap_kind`=2'b10: single `trap_err` pulse, zero `csr_we` cycles, `trap_cnt` unchanged, `trap_ready` back next cycle.
- `rst` driven low asynchronously during W_CAUSE: all outputs 0 immediately without waiting for a clock edge, mcause never written; a fresh ecall after release runs the full sequence.
- Preload `trap_cnt` path by running 2 traps after forcing the count to 32'hFFFFFFFF via a bench hook: count reads 0, then 1.

Source files
------------

// File: rtl/csr_trap_seq.sv
// csr_trap_seq: multi-cycle ecall/mret sequencer driving the M-mode CSR write port and a fetch redirect
//   clk, rst (async, active-low)
//   trap_valid/trap_ready/trap_kind/trap_pc : one request per handshake (kind 00 ecall, 01 mret, 1x illegal)
//   csr_we/csr_waddr/csr_wdata              : CSR write port (0 mstatus, 1 mtvec, 2 mepc, 3 mcause)
//   csr_raddr/csr_rdata                     : combinational CSR read port
//   redir_valid/redir_pc/redir_ready        : PC redirect to fetch
//   trap_err                                : one-cycle pulse for an illegal kind
//   trap_cnt                                : completed redirects, wrapping
module csr_trap_seq #(
    parameter logic [31:0] ECALL_CAUSE = 32'hb
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_valid,
    output logic        trap_ready,
    input  logic [1:0]  trap_kind,
    input  logic [31:0] trap_pc,
    output logic        csr_we,
    output logic [1:0]  csr_waddr,
    output logic [31:0] csr_wdata,
    output logic [1:0]  csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready,
    output logic        trap_err,
    output logic [31:0] trap_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_W_EPC, S_W_CAUSE, S_W_STAT_E, S_W_STAT_R, S_REDIR, S_ERR} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_cnt;
    logic        r_mret;
    logic [31:0] w_stat_e, w_stat_r;
    // ecall: MPIE <- MIE, MIE <- 0, MPP <- M
    assign w_stat_e = {csr_rdata[31:13], 2'b11, csr_rdata[10:8], csr_rdata[3], csr_rdata[6:4], 1'b0, csr_rdata[2:0]};
    // mret: MIE <- MPIE, MPIE <- 1, MPP stays M (only M-mode exists)
    assign w_stat_r = {csr_rdata[31:13], 2'b11, csr_rdata[10:8], 1'b1, csr_rdata[6:4], csr_rdata[7], csr_rdata[2:0]};
    assign trap_cnt = r_cnt;
    always_comb begin
        w_next      = r_state;
        trap_ready  = 1'b0;
        csr_we      = 1'b0;
        csr_waddr   = 2'd0;
        csr_wdata   = 32'd0;
        csr_raddr   = 2'd0;
        redir_valid = 1'b0;
        redir_pc    = 32'd0;
        trap_err    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // gated by rst so every output reads 0 while reset is held
                trap_ready = rst;
                if (trap_valid)
                    w_next = trap_kind[1] ? S_ERR : (trap_kind[0] ? S_W_STAT_R : S_W_EPC);
            end
            S_W_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = 2'd2;
                csr_wdata = r_pc;
                w_next    = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = 2'd3;
                csr_wdata = ECALL_CAUSE;
                w_next    = S_W_STAT_E;
            end
            S_W_STAT_E: begin
                csr_we    = 1'b1;
                csr_wdata = w_stat_e;
                w_next    = S_REDIR;
            end
            S_W_STAT_R: begin
                csr_we    = 1'b1;
                csr_wdata = w_stat_r;
                w_next    = S_REDIR;
            end
            S_REDIR: begin
                csr_raddr   = r_mret ? 2'd2 : 2'd1;
                redir_valid = 1'b1;
                redir_pc    = r_mret ? csr_rdata : {csr_rdata[31:2], 2'b00};
                if (redir_ready)
                    w_next = S_IDLE;
            end
            S_ERR: begin
                trap_err = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= 32'd0;
            r_mret  <= 1'b0;
            r_cnt   <= 32'd0;
        end else begin
            r_state <= w_next;
            if (trap_ready && trap_valid) begin
                r_pc   <= trap_pc;
                r_mret <= (trap_kind == 2'b01);
            end
            if (r_state == S_REDIR && redir_ready)
                r_cnt <= r_cnt + 32'd1;
        end
    end
endmodule
